// File: rtl/ddr_pkt_reader_if.sv
// ddr_pkt_reader_if: bundles the descriptor input, the AXI4 read channels (AR/R)
// and the AXI-Stream egress of the DDR packet reader.
//   master modport - the reader: takes descriptors, drives AR/rready/AXIS.
//   slave modport  - the environment: scheduler, DDR controller and MAC side.
interface ddr_pkt_reader_if #(
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 4
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    // Descriptor from the packet scheduler
    logic [ADDR_WIDTH-1:0] desc_addr;
    logic [15:0]           desc_len;
    logic                  desc_valid;
    logic                  desc_ready;

    // AXI4 read address channel
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    // AXI4 read data channel
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    // AXI-Stream egress
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        input  desc_addr, desc_len, desc_valid,
        output desc_ready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        output desc_addr, desc_len, desc_valid,
        input  desc_ready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/ddr_pkt_reader.sv
// ddr_pkt_reader: reads one packet at a time from DDR with AXI4 INCR bursts
// (never crossing 4KB, at most MAX_BURST beats, one AR outstanding) and
// replays it as an AXI-Stream packet with tlast and a byte-accurate tkeep.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - descriptor / AXI AR+R / AXIS bundle (master modport)
//   pkt_cnt   - packets completed on the stream, wraps
//   rd_err    - sticky: bad rresp or rlast out of step with the beat counter
module ddr_pkt_reader #(
    parameter int unsigned ADDR_WIDTH = 31,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic               clk,
    input  logic               rst,
    ddr_pkt_reader_if.master   bus,
    output logic [31:0]        pkt_cnt,
    output logic               rd_err
);
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned KEEP_W     = BEAT_BYTES;
    localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
    localparam int unsigned PAGE_W     = 12 - OFF_W;
    localparam int unsigned PAGE_BEATS = 4096 / BEAT_BYTES;
    localparam int unsigned REM_W      = 17 - OFF_W;
    localparam int unsigned BEATS_W    = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [OFF_W-1:0]      last_bytes_q, last_bytes_d;
    logic [BEATS_W-1:0]    beats_q, beats_d;
    logic [BEATS_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                  arvalid_q, arvalid_d;
    logic                  desc_ready_q, desc_ready_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  rd_err_q, rd_err_d;

    logic                  rready_c;
    logic                  r_hs_c;
    logic                  load_burst_c;
    logic [KEEP_W-1:0]     last_keep_c;
    logic                  unused_ok;

    assign unused_ok = ^{bus.m_axi_rid, bus.desc_addr[OFF_W-1:0]};

    // Burst size: limited by remaining beats, MAX_BURST and the 4KB page end.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [PAGE_W-1:0] page_idx,
                                                       input logic [REM_W-1:0]  rem);
        logic [REM_W-1:0] b;
        logic [REM_W-1:0] to_page;
        to_page = REM_W'(PAGE_BEATS) - REM_W'(page_idx);
        b = rem;
        if (b > REM_W'(MAX_BURST)) b = REM_W'(MAX_BURST);
        if (b > to_page)           b = to_page;
        return BEATS_W'(b);
    endfunction

    // Single output register: accept R only when it is empty or draining.
    assign rready_c    = (state_q == S_RD) && (!tvalid_q || bus.m_axis_tready);
    assign r_hs_c      = bus.m_axi_rvalid && rready_c;
    assign last_keep_c = (last_bytes_q == '0) ? '1 : ~({KEEP_W{1'b1}} << last_bytes_q);

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        last_bytes_d = last_bytes_q;
        beats_d      = beats_q;
        burst_cnt_d  = burst_cnt_q;
        arvalid_d    = arvalid_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        pkt_cnt_d    = pkt_cnt_q;
        rd_err_d     = rd_err_q;
        load_burst_c = 1'b0;

        if (tvalid_q && bus.m_axis_tready) begin
            tvalid_d = 1'b0;
            if (tlast_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.desc_valid && desc_ready_q && (bus.desc_len != 16'd0)) begin
                    addr_d       = {bus.desc_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    rem_d        = REM_W'((17'(bus.desc_len) + 17'(BEAT_BYTES - 1)) >> OFF_W);
                    last_bytes_d = bus.desc_len[OFF_W-1:0];
                    load_burst_c = 1'b1;
                    state_d      = S_AR;
                end
            end
            S_AR: begin
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (r_hs_c) begin
                    tdata_d     = bus.m_axi_rdata;
                    tvalid_d    = 1'b1;
                    tlast_d     = (rem_q == REM_W'(1));
                    tkeep_d     = (rem_q == REM_W'(1)) ? last_keep_c : '1;
                    rem_d       = rem_q - REM_W'(1);
                    burst_cnt_d = burst_cnt_q - BEATS_W'(1);
                    // Burst end comes from our own counter; rlast is only cross-checked.
                    if ((bus.m_axi_rresp != 2'b00) ||
                        (bus.m_axi_rlast != (burst_cnt_q == BEATS_W'(1))))
                        rd_err_d = 1'b1;
                    if (burst_cnt_q == BEATS_W'(1)) begin
                        addr_d = addr_q + (ADDR_WIDTH'(beats_q) << OFF_W);
                        if (rem_q == REM_W'(1)) begin
                            state_d = S_IDLE;
                        end else begin
                            load_burst_c = 1'b1;
                            state_d      = S_AR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Size the next burst from the already-updated address and remainder.
        if (load_burst_c) begin
            beats_d     = burst_beats(addr_d[11:OFF_W], rem_d);
            burst_cnt_d = beats_d;
            arvalid_d   = 1'b1;
        end

        desc_ready_d = (state_d == S_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            last_bytes_q <= '0;
            beats_q      <= '0;
            burst_cnt_q  <= '0;
            arvalid_q    <= 1'b0;
            desc_ready_q <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            pkt_cnt_q    <= '0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            last_bytes_q <= last_bytes_d;
            beats_q      <= beats_d;
            burst_cnt_q  <= burst_cnt_d;
            arvalid_q    <= arvalid_d;
            desc_ready_q <= desc_ready_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            pkt_cnt_q    <= pkt_cnt_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign bus.desc_ready    = desc_ready_q;
    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = 8'(beats_q - BEATS_W'(1));
    assign bus.m_axi_arsize  = 3'(OFF_W);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_c;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tkeep  = tkeep_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign pkt_cnt           = pkt_cnt_q;
    assign rd_err            = rd_err_q;
endmodule

// File: tb/tb_ddr_pkt_reader.sv
// tb_ddr_pkt_reader: directed descriptors with hand-computed AR sequences,
// a DDR slave model serving a pattern memory, and a scoreboard monitor that
// checks every AR and every stream beat as the DUT presents it.
module tb_ddr_pkt_reader;
    localparam int unsigned AW = 31;
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 4;
    localparam int unsigned KW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_cnt;
    logic        rd_err;

    ddr_pkt_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    ddr_pkt_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pkt_cnt (pkt_cnt),
        .rd_err  (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    beat_t         exp_q[$];
    ar_t           exp_ar_q[$];
    ar_t           pend_q[$];
    int            total = 0;
    int            bad = 0;
    int            ar_seen = 0;
    bit            ar_hs = 0, r_hs = 0, t_hs = 0;
    int            tready_mode = 0;
    bit            r_rand = 0;
    bit            inj_en = 0;
    logic [AW-1:0] inj_addr = '0;
    int            r_idx = 0;
    bit            rvalid_hold = 0;
    bit            tog = 0;
    logic [AW-1:0] ba_drv;
    ar_t           ar_tmp;
    ar_t           e_ar;
    beat_t         e_bt;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = (32'(a) << 4) ^ 32'(k) ^ 32'h5A5A_0000;
        return d;
    endfunction

    function automatic logic [KW-1:0] last_keep(input int lb);
        logic [KW-1:0] m;
        m = '0;
        if (lb == 0) m = '1;
        else for (int k = 0; k < lb; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
        ar_t t;
        t.addr = a;
        t.len  = l;
        exp_ar_q.push_back(t);
    endtask

    task automatic send_desc(input logic [AW-1:0] a, input logic [15:0] len, input bit chk_lat);
        bit            acc;
        int            n;
        int            nb;
        logic [AW-1:0] base;
        beat_t         b;
        acc = 0;
        n   = 0;
        @(negedge clk);
        bus.desc_addr  = a;
        bus.desc_len   = len;
        bus.desc_valid = 1'b1;
        while (!acc && n < 400) begin
            #1;
            if (bus.desc_ready) acc = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL desc_accept: got no desc_ready want accept of addr %0h", a);
        end else begin
            base = {a[AW-1:6], 6'b0};
            nb   = (int'(len) + 63) / 64;
            for (int i = 0; i < nb; i++) begin
                b.data = mem_word(base + AW'(i * 64));
                b.last = (i == nb - 1);
                b.keep = b.last ? last_keep(int'(len) % 64) : '1;
                exp_q.push_back(b);
            end
        end
        @(negedge clk);
        bus.desc_valid = 1'b0;
        if (chk_lat && acc) begin
            #1;
            chk("arvalid_latency", DW'(bus.m_axi_arvalid), DW'(1'b1));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_ar_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got beats_left=%0d ars_left=%0d want 0", exp_q.size(), exp_ar_q.size());
            exp_q.delete();
            exp_ar_q.delete();
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arvalid"},    DW'(bus.m_axi_arvalid), DW'(1'b0));
        chk({tag, "_rready"},     DW'(bus.m_axi_rready),  DW'(1'b0));
        chk({tag, "_tvalid"},     DW'(bus.m_axis_tvalid), DW'(1'b0));
        chk({tag, "_tlast"},      DW'(bus.m_axis_tlast),  DW'(1'b0));
        chk({tag, "_tkeep"},      DW'(bus.m_axis_tkeep),  DW'(64'h0));
        chk({tag, "_desc_ready"}, DW'(bus.desc_ready),    DW'(1'b0));
        chk({tag, "_pkt_cnt"},    DW'(pkt_cnt),           DW'(32'd0));
        chk({tag, "_rd_err"},     DW'(rd_err),            DW'(1'b0));
    endtask

    // DDR slave and stream sink: drive at negedge, resolve handshakes just after.
    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_axi_arready = 1'b1;
            tog = ~tog;
            bus.m_axis_tready = (tready_mode == 0) ? 1'b1 : tog;
            if (!rvalid_hold) begin
                if (pend_q.size() > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
                    ba_drv = pend_q[0].addr + AW'(r_idx * 64);
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = mem_word(ba_drv);
                    bus.m_axi_rlast  = (r_idx == int'(pend_q[0].len));
                    bus.m_axi_rresp  = (inj_en && ba_drv == inj_addr) ? 2'b10 : 2'b00;
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                    bus.m_axi_rlast  = 1'b0;
                    bus.m_axi_rresp  = 2'b00;
                end
            end
            #1;
            if (rst) begin
                ar_hs = 0;
                r_hs  = 0;
                t_hs  = 0;
                pend_q.delete();
                r_idx = 0;
                rvalid_hold = 0;
                bus.m_axi_rvalid = 1'b0;
            end else begin
                ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
                r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
                t_hs  = bus.m_axis_tvalid && bus.m_axis_tready;
                if (ar_hs) begin
                    ar_tmp.addr = bus.m_axi_araddr;
                    ar_tmp.len  = bus.m_axi_arlen;
                    pend_q.push_back(ar_tmp);
                end
                if (r_hs) begin
                    if (r_idx == int'(pend_q[0].len)) begin
                        void'(pend_q.pop_front());
                        r_idx = 0;
                    end else begin
                        r_idx++;
                    end
                end
                rvalid_hold = bus.m_axi_rvalid && !r_hs;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ar_hs) begin
                ar_seen++;
                if (exp_ar_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ar_unexpected: got araddr %0h want no AR", bus.m_axi_araddr);
                end else begin
                    e_ar = exp_ar_q.pop_front();
                    chk("araddr",  DW'(bus.m_axi_araddr),  DW'(e_ar.addr));
                    chk("arlen",   DW'(bus.m_axi_arlen),   DW'(e_ar.len));
                    chk("arsize",  DW'(bus.m_axi_arsize),  DW'(3'd6));
                    chk("arburst", DW'(bus.m_axi_arburst), DW'(2'b01));
                    chk("arid",    DW'(bus.m_axi_arid),    DW'(4'd0));
                end
            end
            if (t_hs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got tdata %0h want no beat", bus.m_axis_tdata[31:0]);
                end else begin
                    e_bt = exp_q.pop_front();
                    chk("tdata", bus.m_axis_tdata,     e_bt.data);
                    chk("tkeep", DW'(bus.m_axis_tkeep), DW'(e_bt.keep));
                    chk("tlast", DW'(bus.m_axis_tlast), DW'(e_bt.last));
                end
            end
            if (!rst && bus.m_axis_tvalid && !bus.m_axis_tready)
                chk("rready_bp", DW'(bus.m_axi_rready), DW'(1'b0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.desc_addr  = '0;
        bus.desc_len   = '0;
        bus.desc_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // One full beat
        push_ar(31'h1000, 8'd0);
        send_desc(31'h1000, 16'd64, 1'b1);
        wait_drain(200);
        chk("pkt_cnt_t1", DW'(pkt_cnt), DW'(32'd1));

        // 7 beats, 16 bytes on the last
        push_ar(31'h0, 8'd6);
        send_desc(31'h0, 16'd400, 1'b0);
        wait_drain(200);
        chk("pkt_cnt_t2", DW'(pkt_cnt), DW'(32'd2));

        // 4KB crossing: 1 beat then 18
        push_ar(31'h0FC0, 8'd0);
        push_ar(31'h1000, 8'd17);
        send_desc(31'h0FC0, 16'd1200, 1'b0);
        wait_drain(300);
        chk("pkt_cnt_t3", DW'(pkt_cnt), DW'(32'd3));

        // MAX_BURST split: 2 x 64 beats
        push_ar(31'h0, 8'd63);
        push_ar(31'h1000, 8'd63);
        send_desc(31'h0, 16'd8192, 1'b0);
        wait_drain(600);
        chk("pkt_cnt_t4", DW'(pkt_cnt), DW'(32'd4));
        chk("rd_err_clean", DW'(rd_err), DW'(1'b0));

        // Backpressure, random rvalid, back-to-back 64/128-byte packets
        tready_mode = 1;
        r_rand = 1;
        for (int i = 0; i < 100; i++) begin
            push_ar(31'h20000 + AW'(i * 128), (i % 2 == 1) ? 8'd1 : 8'd0);
            send_desc(31'h20000 + AW'(i * 128), (i % 2 == 1) ? 16'd128 : 16'd64, 1'b0);
        end
        wait_drain(2000);
        chk("pkt_cnt_t5", DW'(pkt_cnt), DW'(32'd104));
        chk("rd_err_t5", DW'(rd_err), DW'(1'b0));
        tready_mode = 0;
        r_rand = 0;

        // SLVERR on beat 2 of 3
        inj_en = 1;
        inj_addr = 31'h3040;
        push_ar(31'h3000, 8'd2);
        send_desc(31'h3000, 16'd192, 1'b0);
        wait_drain(200);
        inj_en = 0;
        chk("rd_err_set", DW'(rd_err), DW'(1'b1));
        chk("pkt_cnt_t6a", DW'(pkt_cnt), DW'(32'd105));

        // Zero-length descriptor
        begin
            int ar_before;
            ar_before = ar_seen;
            send_desc(31'h5000, 16'd0, 1'b0);
            repeat (10) @(negedge clk);
            #1;
            chk("zero_len_no_ar", DW'(ar_seen), DW'(ar_before));
            chk("zero_len_pkt_cnt", DW'(pkt_cnt), DW'(32'd105));
            chk("zero_len_desc_ready", DW'(bus.desc_ready), DW'(1'b1));
        end

        // Reset in the middle of a 10-beat read
        push_ar(31'h6000, 8'd9);
        send_desc(31'h6000, 16'd640, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_ar_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_rd");
        @(negedge clk);
        #1;
        chk("desc_ready_after_rst", DW'(bus.desc_ready), DW'(1'b1));

        // Normal operation after reset
        push_ar(31'h1000, 8'd0);
        send_desc(31'h1000, 16'd64, 1'b0);
        wait_drain(200);
        chk("pkt_cnt_post_rst", DW'(pkt_cnt), DW'(32'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_pkt_reader.md
Name: ddr_pkt_reader

Overview:
Egress-side DDR packet reader, the counterpart of the ingress path that writes packets to DDR. Accepts one packet descriptor at a time (DDR byte address and byte length) and issues AXI4 INCR read bursts. Returns the read data as an AXI-Stream packet with tlast and a tkeep that reflects the byte count. Sits between the packet scheduler (descriptor source) and the egress MAC stream.

Parameters:
ADDR_WIDTH, 31, AXI address width
DATA_WIDTH, 512, AXI/AXIS data width; BEAT_BYTES = DATA_WIDTH/8 = 64
ID_WIDTH, 4, AXI ID width
MAX_BURST, 64, max beats per AR burst (1..256)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
desc_addr  in  ADDR_WIDTH  packet start byte address; low log2(BEAT_BYTES) bits ignored (treated as 0)
desc_len  in  16  packet length in bytes
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accept
m_axi_arid  out  ID_WIDTH  constant 0
m_axi_araddr  out  ADDR_WIDTH  burst start address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant log2(BEAT_BYTES) (6)
m_axi_arburst  out  2  constant 2'b01 INCR
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  DATA_WIDTH  packet data
m_axis_tkeep  out  DATA_WIDTH/8  byte enables
m_axis_tlast  out  1  last beat of packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
pkt_cnt  out  32  packets sent on m_axis; wraps
rd_err  out  1  sticky error flag

Behaviour:
- Reset: arvalid, rready, tvalid, tlast and desc_ready are 0; tkeep = 0; pkt_cnt = 0; rd_err = 0; FSM = IDLE. Reset mid-packet abandons the packet immediately; outstanding R beats arriving after reset are accepted only when a new burst is in flight (no scrubbing is required).
- FSM IDLE: desc_ready = 1. On desc_valid&&desc_ready:
  - desc_len = 0: the descriptor is consumed and the FSM stays in IDLE. No AR is issued and nothing is output.
  - Otherwise latch addr and rem_beats = ceil(len/BEAT_BYTES) and last_bytes = len mod BEAT_BYTES (0 means full beat), then go to AR.
- AR: arvalid = 1 starting the cycle after the accept or the previous burst's completion. Burst beats = min(rem_beats, MAX_BURST, beats to next 4KB boundary = (4096 - addr[11:0]) / BEAT_BYTES). araddr, arlen and the other AR fields stay stable until arready. On handshake go to RD.
- RD: rready = !tvalid || m_axis_tready (single output register, no combinational data path). On each R handshake:
  - tdata <= rdata and tvalid <= 1 on the next cycle.
  - burst_cnt is decremented.
  - tlast <= (this is the packet's final beat). tkeep <= all ones, except on the final beat, where it is the low last_bytes bits set (all ones if last_bytes = 0).
  - At the end of a burst (burst_cnt reaches 0): addr += beats*BEAT_BYTES and rem_beats -= beats. If rem_beats > 0, go to AR; else go to IDLE.
- Burst end is determined by the internal beat counter, not by rlast. rd_err is set if rlast disagrees with the counter, or if any rresp != 2'b00. Data is still forwarded. rd_err clears only on reset.
- Exactly one AR outstanding. No descriptor is accepted until the last R beat of the current packet has been handshaked. The output register may still hold that beat when the next descriptor is accepted.
- m_axis: tvalid, once asserted, holds with stable data until tready. pkt_cnt increments on the tvalid&&tready&&tlast cycle.
- Latency: desc accept at cycle T gives arvalid at T+1. An R handshake at T gives tvalid at T+1.
- Simultaneous events: in the same cycle, an output beat can be consumed and a new R beat loaded (full throughput, 1 beat/cycle).

Test Plan:
1. desc addr 0x1000, len 64; arready tied 1 -> one AR with araddr 0x1000, arlen 0, arsize 6, arburst 1; one m_axis beat with tkeep all ones and tlast = 1; pkt_cnt = 1.
2. addr 0x0, len 400 -> single AR with arlen 6. 7 beats output; beat 7 has tlast = 1 and tkeep = 64'h0000_0000_0000_FFFF; beats 1-6 have tkeep all ones.
3. addr 0x0FC0, len 1200 (19 beats, crosses 4KB) -> AR0 with araddr 0xFC0, arlen 0; AR1 with araddr 0x1000, arlen 17. 19 beats output in order; tkeep on the last beat has the low 48 bits set.
4. addr 0x0, len 8192, MAX_BURST 64 -> two ARs with araddr 0x0 and 0x1000, each arlen 63. 128 beats output with tlast only on beat 128.
5. Backpressure: tready toggles each cycle and rvalid is random across 100 back-to-back 64-byte and 128-byte descriptors -> beat counts match, data matches the memory model with none dropped or duplicated, and pkt_cnt = 100. rready is never high while tvalid && !tready.
6. Errors and corner cases:
   - rresp = 2'b10 on beat 2 of a 3-beat packet -> rd_err = 1 and the packet completes.
   - desc_len = 0 -> no AR is issued and pkt_cnt is unchanged.
   - rst during RD -> all outputs return to their reset values next cycle and desc_ready = 1 afterwards.
